// File: rtl/ucsbece154a_lsu.sv
// ucsbece154a_lsu: load/store unit between the core memory stage and a
// word-addressed data memory. Turns RV32I byte/half/word loads and stores into
// word-only dmem accesses (read-modify-write for sub-word stores, sign/zero
// extension for sub-word loads) behind a req/done handshake.
//
// Optional feature macro: UCSBECE154A_LSU_MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses skip memory and raise err_o
//   undefined - misaligned addresses are coerced down to alignment, err_o = 0
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req_i, we_i         request (sampled in IDLE only), 1=store 0=load
//   funct3_i            RV32I size/sign code (bit1=1 means word)
//   addr_i, wdata_i     byte address, right-aligned store data
//   ready_o, done_o     idle indicator, one-cycle completion pulse
//   rdata_o, err_o      extended load result (held), misaligned flag
//   dmem_a_o/wd_o/we_o  word address, write data, write enable to dmem
//   dmem_rd_i           combinational dmem read data
module ucsbece154a_lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [31:0] dmem_a_o,
    output logic [31:0] dmem_wd_o,
    output logic        dmem_we_o,
    input  logic [31:0] dmem_rd_i
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e      r_state, w_state_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_in_word, w_in_half;
    logic [31:0] w_addr_aligned;
    logic [31:0] w_lane_b, w_lane_h;
    logic [31:0] w_load_ext;
    logic [31:0] w_merged;

    assign w_accept  = (r_state == StIdle) && req_i;
    assign w_in_word = funct3_i[1];
    assign w_in_half = (funct3_i[1:0] == 2'b01);

    // Coerce down to natural alignment; harmless for aligned addresses.
    always_comb begin
        w_addr_aligned = addr_i;
        if (w_in_word) begin
            w_addr_aligned[1:0] = 2'b00;
        end else if (w_in_half) begin
            w_addr_aligned[0] = 1'b0;
        end
    end

`ifdef UCSBECE154A_LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_err;
    assign w_misalign = (w_in_word && (addr_i[1:0] != 2'b00)) || (w_in_half && addr_i[0]);
    assign err_o      = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_misalign;
        end
    end
`else
    assign err_o = 1'b0;
`endif

    // Load lane extraction from the word currently on dmem_rd_i.
    assign w_lane_b = dmem_rd_i >> {r_addr[1:0], 3'b000};
    assign w_lane_h = dmem_rd_i >> {r_addr[1], 4'b0000};

    always_comb begin
        if (r_funct3[1]) begin
            w_load_ext = dmem_rd_i;
        end else if (r_funct3[0]) begin
            w_load_ext = {{16{~r_funct3[2] & w_lane_h[15]}}, w_lane_h[15:0]};
        end else begin
            w_load_ext = {{24{~r_funct3[2] & w_lane_b[7]}}, w_lane_b[7:0]};
        end
    end

    // Replace only the addressed lanes of the previously read word.
    always_comb begin
        w_merged = r_merge;
        if (r_funct3[0]) begin
            if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
            else           w_merged[15:0]  = r_wdata[15:0];
        end else begin
            unique case (r_addr[1:0])
                2'b00: w_merged[7:0]   = r_wdata[7:0];
                2'b01: w_merged[15:8]  = r_wdata[7:0];
                2'b10: w_merged[23:16] = r_wdata[7:0];
                2'b11: w_merged[31:24] = r_wdata[7:0];
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (req_i) begin
`ifdef UCSBECE154A_LSU_MISALIGN_TRAP_EN
                    if (w_misalign)                w_state_next = StDone;
                    else if (we_i && funct3_i[1])  w_state_next = StWr;
                    else                           w_state_next = StRd;
`else
                    if (we_i && funct3_i[1]) w_state_next = StWr;
                    else                     w_state_next = StRd;
`endif
                end
            end
            StRd:   w_state_next = r_we ? StWr : StDone;
            StWr:   w_state_next = StDone;
            StDone: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_merge  <= 32'h0;
            r_rdata  <= 32'h0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_we     <= we_i;
                r_funct3 <= funct3_i;
                r_addr   <= w_addr_aligned;
                r_wdata  <= wdata_i;
`ifdef UCSBECE154A_LSU_MISALIGN_TRAP_EN
                if (w_misalign && !we_i) begin
                    r_rdata <= 32'h0;
                end
`endif
            end
            if (r_state == StRd) begin
                if (r_we) r_merge <= dmem_rd_i;
                else      r_rdata <= w_load_ext;
            end
        end
    end

    assign ready_o   = (r_state == StIdle);
    assign done_o    = (r_state == StDone);
    assign rdata_o   = r_rdata;
    assign dmem_a_o  = {r_addr[31:2], 2'b00};
    assign dmem_we_o = (r_state == StWr);
    assign dmem_wd_o = (r_state != StWr) ? 32'h0 : (r_funct3[1] ? r_wdata : w_merged);

endmodule

// File: tb/tb_ucsbece154a_lsu.sv
// Self-checking bench for ucsbece154a_lsu: reset values, spec vector table,
// req-held throughput sequence, randomized accesses against a byte-level
// memory model, and reset during a write cycle.
module tb_ucsbece154a_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_i, we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        ready_o, done_o, err_o, dmem_we_o;
    logic [31:0] rdata_o, dmem_a_o, dmem_wd_o, dmem_rd_i;

    logic [31:0] dmem [0:63];
    logic [7:0]  mb   [0:255];
    logic [31:0] model_rdata;

    int checks = 0;
    int failures = 0;

    ucsbece154a_lsu dut (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_i),
        .we_i      (we_i),
        .funct3_i  (funct3_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .ready_o   (ready_o),
        .done_o    (done_o),
        .rdata_o   (rdata_o),
        .err_o     (err_o),
        .dmem_a_o  (dmem_a_o),
        .dmem_wd_o (dmem_wd_o),
        .dmem_we_o (dmem_we_o),
        .dmem_rd_i (dmem_rd_i)
    );

    always #5 clk = ~clk;

    assign dmem_rd_i = dmem[dmem_a_o[7:2]];
    always @(posedge clk) if (dmem_we_o) dmem[dmem_a_o[7:2]] <= dmem_wd_o;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int a);
        model_word = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
    endfunction

    // Reference behaviour computed from the access rules on a byte array.
    function automatic void model_access(input logic we, input logic [2:0] f3,
                                         input int addr, input logic [31:0] wdata,
                                         output logic exp_err, output int exp_lat,
                                         output int exp_wecnt);
        int size, a;
        bit mis;
        longint v;
        size = f3[1] ? 4 : (f3[0] ? 2 : 1);
        mis  = (addr % size) != 0;
        exp_err = 1'b0;
`ifdef UCSBECE154A_LSU_MISALIGN_TRAP_EN
        if (mis) begin
            exp_err   = 1'b1;
            exp_lat   = 1;
            exp_wecnt = 0;
            if (!we) model_rdata = 32'h0;
            return;
        end
`else
        if (mis) a = 0;
`endif
        a = addr - (addr % size);
        if (we) begin
            for (int i = 0; i < size; i++) mb[a+i] = 8'((wdata >> (8 * i)) & 32'hFF);
            exp_lat   = (size == 4) ? 2 : 3;
            exp_wecnt = 1;
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v = v + (longint'(mb[a+i]) << (8 * i));
            if (size < 4 && !f3[2] && v >= (longint'(1) << (8 * size - 1)))
                v = v - (longint'(1) << (8 * size));
            model_rdata = 32'(v);
            exp_lat     = 2;
            exp_wecnt   = 0;
        end
    endfunction

    // Issue one access from IDLE and wait (bounded) for done_o.
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rd,
                              output logic er, output int lat, output int wecnt);
        @(posedge clk); #1;
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wdata;
        @(posedge clk); #1;
        req_i = 1'b0;
        lat   = 1;
        wecnt = int'(dmem_we_o);
        while (!done_o && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            wecnt += int'(dmem_we_o);
        end
        rd = rdata_o;
        er = err_o;
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] rd;
        logic        er, m_err;
        int          lat, wecnt, m_lat, m_wecnt;
        int          c, done1, done2, dcount;
        logic [31:0] saved;

        reset = 1'b1; req_i = 1'b0; we_i = 1'b0; funct3_i = 3'b0; addr_i = 32'h0;
        wdata_i = 32'h0;
        for (int i = 0; i < 64; i++) dmem[i] = $urandom;
        dmem[4] = 32'h8899AABB;
        dmem[8] = 32'h0;
        dmem[9] = 32'h0;
        for (int i = 0; i < 256; i++) mb[i] = 8'(dmem[i/4] >> (8 * (i % 4)));
        model_rdata = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check32("rst_ready", 32'(ready_o), 32'h1);
        check32("rst_done", 32'(done_o), 32'h0);
        check32("rst_err", 32'(err_o), 32'h0);
        check32("rst_we", 32'(dmem_we_o), 32'h0);
        check32("rst_rdata", rdata_o, 32'h0);
        check32("rst_a", dmem_a_o, 32'h0);
        check32("rst_wd", dmem_wd_o, 32'h0);
        reset = 1'b0;

        vecs[0] = '{"lb_11",  1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 32'h0};
        vecs[1] = '{"lbu_11", 1'b0, 3'b100, 32'h11, 32'h0,        32'h000000AA, 1'b0, 2, 32'h0};
        vecs[2] = '{"lh_12",  1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8899, 1'b0, 2, 32'h0};
        vecs[3] = '{"lhu_12", 1'b0, 3'b101, 32'h12, 32'h0,        32'h00008899, 1'b0, 2, 32'h0};
        vecs[4] = '{"lw_10",  1'b0, 3'b010, 32'h10, 32'h0,        32'h8899AABB, 1'b0, 2, 32'h0};
        vecs[5] = '{"sh_12",  1'b1, 3'b001, 32'h12, 32'hDEAD1234, 32'h8899AABB, 1'b0, 3,
                    32'h1234AABB};
        vecs[6] = '{"sb_10",  1'b1, 3'b000, 32'h10, 32'h00000077, 32'h8899AABB, 1'b0, 3,
                    32'h1234AA77};
        vecs[7] = '{"sw_20",  1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h8899AABB, 1'b0, 2,
                    32'hCAFEF00D};
`ifdef UCSBECE154A_LSU_MISALIGN_TRAP_EN
        vecs[8] = '{"lw_13",  1'b0, 3'b010, 32'h13, 32'h0,        32'h00000000, 1'b1, 1, 32'h0};
`else
        vecs[8] = '{"lw_13",  1'b0, 3'b010, 32'h13, 32'h0,        32'h1234AA77, 1'b0, 2, 32'h0};
`endif

        foreach (vecs[i]) begin
            model_access(vecs[i].we, vecs[i].f3, int'(vecs[i].addr), vecs[i].wdata,
                         m_err, m_lat, m_wecnt);
            run_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, wecnt);
            check32({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
            check32({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
            check32({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
            check32({vecs[i].name, "_wecnt"}, 32'(wecnt), vecs[i].we ? 32'h1 : 32'h0);
            if (vecs[i].we) check32({vecs[i].name, "_mem"}, dmem[vecs[i].addr[7:2]],
                                    vecs[i].exp_mem);
        end

        // req_i held high: word store then load, accepted 3 cycles apart.
        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h24; wdata_i = 32'h12345678;
        c = 0; done1 = 0; done2 = 0;
        while (done2 == 0 && c < 12) begin
            @(posedge clk); #1;
            c++;
            if (done_o) begin
                if (done1 == 0) begin
                    done1 = c;
                    we_i = 1'b0;
                end else begin
                    done2 = c;
                    req_i = 1'b0;
                end
            end
        end
        model_access(1'b1, 3'b010, 32'h24, 32'h12345678, m_err, m_lat, m_wecnt);
        model_access(1'b0, 3'b010, 32'h24, 32'h0, m_err, m_lat, m_wecnt);
        check32("held_done1", 32'(done1), 32'd2);
        check32("held_done2", 32'(done2), 32'd5);
        check32("held_mem", dmem[9], 32'h12345678);
        check32("held_rdata", rdata_o, 32'h12345678);

        // Randomized accesses against the byte-level model.
        for (int n = 0; n < 60; n++) begin
            logic        rwe;
            logic [2:0]  rf3;
            logic [31:0] raddr, rwd;
            rwe   = 1'($urandom_range(0, 1));
            rf3   = 3'($urandom_range(0, 7));
            raddr = 32'($urandom_range(0, 255));
            rwd   = $urandom;
            model_access(rwe, rf3, int'(raddr), rwd, m_err, m_lat, m_wecnt);
            run_access(rwe, rf3, raddr, rwd, rd, er, lat, wecnt);
            check32($sformatf("rnd%0d_rdata", n), rd, model_rdata);
            check32($sformatf("rnd%0d_err", n), 32'(er), 32'(m_err));
            check32($sformatf("rnd%0d_lat", n), 32'(lat), 32'(m_lat));
            check32($sformatf("rnd%0d_wecnt", n), 32'(wecnt), 32'(m_wecnt));
            check32($sformatf("rnd%0d_mem", n), dmem[raddr[7:2]],
                    model_word(int'({raddr[7:2], 2'b00})));
        end

        // Reset asserted during the WR cycle of sb 0x10.
        saved = dmem[4];
        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b000; addr_i = 32'h10; wdata_i = 32'h55;
        @(posedge clk); #1;
        req_i = 1'b0;
        @(posedge clk); #1;
        check32("rstwr_we_before", 32'(dmem_we_o), 32'h1);
        reset = 1'b1;
        #1;
        check32("rstwr_we_async", 32'(dmem_we_o), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        check32("rstwr_ready", 32'(ready_o), 32'h1);
        dcount = 0;
        repeat (4) begin
            @(posedge clk); #1;
            dcount += int'(done_o);
        end
        check32("rstwr_no_done", 32'(dcount), 32'h0);
        check32("rstwr_mem", dmem[4], saved);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
